biriscv_itcm_responder: RTL and testbench
=========================================

// Module: biriscv_itcm_responder
// PURPOSE
//  Responder end of the frontend instruction-fetch interface: accepts rd/flush/invalidate
//  requests, returns one 64-bit fetch word (two instr slots) per accepted rd from a local
//  instruction RAM, with configurable wait states, range/alignment error and user-mode
//  page-fault checks. Sits where the icache would. A side write port preloads the RAM.
// PARAMETERS
//  MEM_BASE     32'h8000_0000  byte base address of the RAM window
//  MEM_WORDS_W  12             log2(number of 64-bit words); window = 8<<MEM_WORDS_W bytes
//  WAIT_STATES  0              extra cycles between accept and response (0..15)
//  FLUSH_CYCLES 4              cycles accept held low after a flush/invalidate (>=1)
//  USER_BASE    32'h8000_1000  lowest byte address user-mode (priv 2'b00) may fetch
// PORTS
//  clk_i             in  1   clock
//  rst_i             in  1   synchronous reset, active high
//  req_rd_i          in  1   fetch read request
//  req_flush_i       in  1   flush request (no response)
//  req_invalidate_i  in  1   invalidate request (no response)
//  req_pc_i          in  32  fetch byte address
//  req_priv_i        in  2   privilege of fetch (0=U,1=S,3=M)
//  req_accept_o      out 1   request consumed this cycle
//  resp_valid_o      out 1   response valid (1-cycle pulse, no backpressure)
//  resp_inst_o       out 64  fetch word; [31:0] at pc&~7, [63:32] at (pc&~7)+4
//  resp_error_o      out 1   bus error (out of window or pc[1:0]!=0)
//  resp_page_fault_o out 1   user fetch below USER_BASE
//  wr_en_i           in  1   preload write enable
//  wr_addr_i         in  MEM_WORDS_W  word index
//  wr_data_i         in  64  write data
//  wr_strb_i         in  8   byte enables
// BEHAVIOUR
//  - Reset: req_accept_o=0 during reset; resp_valid_o/resp_error_o/resp_page_fault_o=0,
//    resp_inst_o=0, state=IDLE, counters=0. RAM contents not reset. Reset mid-operation
//    drops any pending response; no resp_valid_o after reset deasserts for it.
//  - FSM: IDLE, WAIT, RESP, FLUSH. Exactly one rd outstanding.
//  - req_accept_o (comb) = !rst_i & !wr_en_i & (state==IDLE | state==RESP).
//  - Accept in IDLE/RESP: flush|invalidate has priority over rd -> FLUSH, counter=FLUSH_CYCLES-1,
//    rd not serviced (initiator must re-present it). Else rd -> WAIT if WAIT_STATES>0
//    (counter=WAIT_STATES-1), else RESP. No request -> IDLE.
//  - WAIT: counter decrements; at 0 -> RESP. FLUSH: at 0 -> IDLE; no response issued.
//  - RESP: resp_valid_o=1 for exactly that cycle; latency accept(T) -> valid at
//    T+1+WAIT_STATES. Back-to-back accepts in RESP give 1 word/cycle at WAIT_STATES=0.
//  - Request fields (pc, priv) registered at accept; RAM read index = (pc-MEM_BASE)>>3,
//    read issued so data lands in RESP cycle.
//  - Checks (on registered pc): error if pc[1:0]!=0 or pc<MEM_BASE or
//    pc-MEM_BASE >= 8<<MEM_WORDS_W (32-bit unsigned compare, no wrap). Else page_fault if
//    priv==2'b00 & pc<USER_BASE. Error has priority; either fault forces resp_inst_o=0.
//    Fault flags are only meaningful with resp_valid_o; 0 otherwise.
//  - Write port: byte-masked write at wr_addr_i, takes effect next cycle; blocks accept
//    that cycle. Write to word being read for a pending response: response returns data
//    read at issue (old data) if written after the read cycle.
//  - flush/invalidate have identical timing; no RAM side effect.
// TESTING
//  1 Preload word0=64'h00000013_00100093; rd pc=MEM_BASE priv=3, WAIT_STATES=0 -> accept T,
//    valid T+1, inst=64'h00000013_00100093, err=0, pf=0.
//  2 Streaming rd pc=MEM_BASE,+8,+16 held high -> accept every cycle, valid T+1..T+3, in order.
//  3 WAIT_STATES=3: rd at T -> valid only at T+4; accept low T+1..T+3, high at T+4.
//  4 rd pc=MEM_BASE+(8<<MEM_WORDS_W) -> err=1, inst=0; pc=MEM_BASE+2 -> err=1;
//    priv=0 pc=MEM_BASE+8 -> pf=1, err=0; priv=0 pc=USER_BASE -> clean.
//  5 flush+rd same cycle -> accept=1, no valid; accept low 4 cycles, rd re-presented then served.
//  6 wr_en_i with rd -> no accept that cycle; rst_i in WAIT -> no valid afterwards, accept=0 in reset.

Source files
------------

// File: rtl/biriscv_itcm_responder_if.sv
// Fetch request/response and RAM preload bundle for the ITCM responder.
// master = fetch initiator + preloader, slave = responder.
interface biriscv_itcm_responder_if #(
  parameter int MEM_WORDS_W = 12
) ();
  logic                   req_rd_i;
  logic                   req_flush_i;
  logic                   req_invalidate_i;
  logic [31:0]            req_pc_i;
  logic [1:0]             req_priv_i;
  logic                   req_accept_o;
  logic                   resp_valid_o;
  logic [63:0]            resp_inst_o;
  logic                   resp_error_o;
  logic                   resp_page_fault_o;
  logic                   wr_en_i;
  logic [MEM_WORDS_W-1:0] wr_addr_i;
  logic [63:0]            wr_data_i;
  logic [7:0]             wr_strb_i;

  modport master (
    output req_rd_i, req_flush_i, req_invalidate_i,
    output req_pc_i, req_priv_i,
    output wr_en_i, wr_addr_i, wr_data_i, wr_strb_i,
    input  req_accept_o, resp_valid_o, resp_inst_o,
    input  resp_error_o, resp_page_fault_o
  );

  modport slave (
    input  req_rd_i, req_flush_i, req_invalidate_i,
    input  req_pc_i, req_priv_i,
    input  wr_en_i, wr_addr_i, wr_data_i, wr_strb_i,
    output req_accept_o, resp_valid_o, resp_inst_o,
    output resp_error_o, resp_page_fault_o
  );
endinterface

// File: rtl/biriscv_itcm_responder.sv
// Instruction-fetch responder: one 64-bit word per accepted rd from local RAM.
// Ports: clk_i, rst_i (sync, active high), bus (slave: fetch req/resp + preload).
module biriscv_itcm_responder #(
  parameter logic [31:0] MEM_BASE     = 32'h8000_0000,
  parameter int          MEM_WORDS_W  = 12,
  parameter int          WAIT_STATES  = 0,
  parameter int          FLUSH_CYCLES = 4,
  parameter logic [31:0] USER_BASE    = 32'h8000_1000
) (
  input logic                     clk_i,
  input logic                     rst_i,
  biriscv_itcm_responder_if.slave bus
);

  localparam int          CW  = 8;
  localparam logic [32:0] WIN = 33'd8 << MEM_WORDS_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_FLUSH
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   accept, load;
  logic [31:0]            pc_q;
  logic [1:0]             priv_q;
  logic [63:0]            mem [2**MEM_WORDS_W];
  logic [63:0]            rdata_q;
  logic [MEM_WORDS_W-1:0] rd_idx;
  logic [31:0]            off;
  logic                   range_err, user_pf, valid;

  assign accept = !rst_i && !bus.wr_en_i &&
                  (state_q == ST_IDLE || state_q == ST_RESP);
  assign bus.req_accept_o = accept;

  // Out-of-window pcs still index somewhere; the data is discarded.
  assign rd_idx = MEM_WORDS_W'((bus.req_pc_i - MEM_BASE) >> 3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (bus.req_flush_i || bus.req_invalidate_i) begin
            state_d = ST_FLUSH;
            cnt_d   = CW'(FLUSH_CYCLES - 1);
          end else if (bus.req_rd_i) begin
            load = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = CW'(WAIT_STATES - 1);
            end else begin
              state_d = ST_RESP;
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      priv_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        pc_q   <= bus.req_pc_i;
        priv_q <= bus.req_priv_i;
      end
    end
  end

  // Read is taken at accept, so later writes to the word do not
  // affect a pending response.
  always_ff @(posedge clk_i) begin
    if (load) rdata_q <= mem[rd_idx];
    if (bus.wr_en_i) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.wr_strb_i[b])
          mem[bus.wr_addr_i][8*b +: 8] <= bus.wr_data_i[8*b +: 8];
      end
    end
  end

  assign off       = pc_q - MEM_BASE;
  assign range_err = (pc_q[1:0] != 2'b00) || (pc_q < MEM_BASE) ||
                     ({1'b0, off} >= WIN);
  assign user_pf   = (priv_q == 2'b00) && (pc_q < USER_BASE);
  assign valid     = (state_q == ST_RESP);

  assign bus.resp_valid_o      = valid;
  assign bus.resp_error_o      = valid && range_err;
  assign bus.resp_page_fault_o = valid && !range_err && user_pf;
  assign bus.resp_inst_o       = (valid && !range_err && !user_pf) ?
                                 rdata_q : 64'h0;

endmodule

// File: tb/tb_biriscv_itcm_responder.sv
// Bench for biriscv_itcm_responder: one instance with no wait states,
// one with three; expected responses are queued per instance.
module tb_biriscv_itcm_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] UBASE = 32'h8000_1000;
  localparam logic [63:0] W0 = 64'h00000013_00100093;
  localparam logic [63:0] W1 = 64'h11111111_22222222;
  localparam logic [63:0] W2 = 64'h33333333_44444444;
  localparam logic [63:0] W3 = 64'hAAAAAAAA_CCCCDDDD;
  localparam logic [63:0] WU = 64'h55555555_66666666;
  localparam logic [63:0] WL = 64'h77777777_88888888;
  localparam logic [63:0] W5 = 64'hDEADBEEF_CAFEF00D;

  typedef struct {
    int unsigned cyc;
    logic [63:0] inst;
    logic        err;
    logic        pf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;
  logic        ev0, ev1;

  biriscv_itcm_responder_if #(.MEM_WORDS_W(12)) if0 ();
  biriscv_itcm_responder_if #(.MEM_WORDS_W(12)) if1 ();

  biriscv_itcm_responder #(.WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(if0.slave)
  );
  biriscv_itcm_responder #(.WAIT_STATES(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(if1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      ev0 = (q0.size() != 0) && (q0[0].cyc == cyc);
      check("valid0", if0.resp_valid_o, ev0);
      if (ev0) begin
        e0 = q0.pop_front();
        check("inst0", if0.resp_inst_o, e0.inst);
        check("err0", if0.resp_error_o, e0.err);
        check("pf0", if0.resp_page_fault_o, e0.pf);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      ev1 = (q1.size() != 0) && (q1[0].cyc == cyc);
      check("valid1", if1.resp_valid_o, ev1);
      if (ev1) begin
        e1 = q1.pop_front();
        check("inst1", if1.resp_inst_o, e1.inst);
        check("err1", if1.resp_error_o, e1.err);
        check("pf1", if1.resp_page_fault_o, e1.pf);
      end
    end
  end

  task automatic wr(input int idx, input logic [63:0] d,
                    input logic [7:0] s);
    if0.wr_en_i = 1'b1; if0.wr_addr_i = 12'(idx);
    if0.wr_data_i = d;  if0.wr_strb_i = s;
    if1.wr_en_i = 1'b1; if1.wr_addr_i = 12'(idx);
    if1.wr_data_i = d;  if1.wr_strb_i = s;
    @(posedge clk); #1;
    if0.wr_en_i = 1'b0;
    if1.wr_en_i = 1'b0;
  endtask

  task automatic idle(input int n);
    if0.req_rd_i = 1'b0;
    if1.req_rd_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input int d, input logic [31:0] pc,
                       input logic [1:0] pv, input logic [63:0] inst,
                       input logic e, input logic p);
    if (d == 0) begin
      if0.req_rd_i = 1'b1; if0.req_pc_i = pc; if0.req_priv_i = pv;
    end else begin
      if1.req_rd_i = 1'b1; if1.req_pc_i = pc; if1.req_priv_i = pv;
    end
    @(negedge clk);
    if (d == 0) begin
      check("accept0", if0.req_accept_o, 1);
      q0.push_back('{cyc + 1, inst, e, p});
    end else begin
      check("accept1", if1.req_accept_o, 1);
      q1.push_back('{cyc + 4, inst, e, p});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    if0.req_rd_i = 0; if0.req_flush_i = 0; if0.req_invalidate_i = 0;
    if0.req_pc_i = BASE; if0.req_priv_i = 2'd3;
    if0.wr_en_i = 0; if0.wr_addr_i = '0; if0.wr_data_i = '0;
    if0.wr_strb_i = '0;
    if1.req_rd_i = 0; if1.req_flush_i = 0; if1.req_invalidate_i = 0;
    if1.req_pc_i = BASE; if1.req_priv_i = 2'd3;
    if1.wr_en_i = 0; if1.wr_addr_i = '0; if1.wr_data_i = '0;
    if1.wr_strb_i = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_accept0", if0.req_accept_o, 0);
    check("rst_accept1", if1.req_accept_o, 0);
    check("rst_valid0", if0.resp_valid_o, 0);
    check("rst_inst0", if0.resp_inst_o, 0);
    check("rst_err0", if0.resp_error_o, 0);
    check("rst_pf0", if0.resp_page_fault_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    wr(0, W0, 8'hFF);
    wr(1, W1, 8'hFF);
    wr(2, W2, 8'hFF);
    wr(3, 64'hAAAAAAAA_BBBBBBBB, 8'hFF);
    wr(3, 64'h99999999_CCCCDDDD, 8'h0F);
    wr(512, WU, 8'hFF);
    wr(4095, WL, 8'hFF);

    issue(0, BASE, 2'd3, W0, 0, 0);
    idle(2);

    issue(0, BASE, 2'd3, W0, 0, 0);
    issue(0, BASE + 8, 2'd3, W1, 0, 0);
    issue(0, BASE + 16, 2'd3, W2, 0, 0);
    issue(0, BASE + 24, 2'd3, W3, 0, 0);
    idle(2);

    issue(0, BASE + 32'h8000, 2'd3, 64'h0, 1, 0);
    issue(0, BASE + 2, 2'd3, 64'h0, 1, 0);
    issue(0, 32'h7FFF_FFF8, 2'd3, 64'h0, 1, 0);
    issue(0, BASE + 8, 2'd0, 64'h0, 0, 1);
    issue(0, BASE + 8, 2'd1, W1, 0, 0);
    issue(0, UBASE, 2'd0, WU, 0, 0);
    issue(0, BASE + 32'h7FF8, 2'd0, WL, 0, 0);
    issue(0, BASE + 6, 2'd0, 64'h0, 1, 0);
    idle(2);

    if0.req_rd_i = 1'b1; if0.req_flush_i = 1'b1;
    if0.req_pc_i = BASE + 16; if0.req_priv_i = 2'd3;
    @(negedge clk);
    check("flush_accept", if0.req_accept_o, 1);
    @(posedge clk); #1;
    if0.req_flush_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("flush_hold", if0.req_accept_o, 0);
      @(posedge clk); #1;
    end
    issue(0, BASE + 16, 2'd3, W2, 0, 0);
    idle(2);

    if0.req_invalidate_i = 1'b1;
    @(negedge clk);
    check("inv_accept", if0.req_accept_o, 1);
    @(posedge clk); #1;
    if0.req_invalidate_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("inv_hold", if0.req_accept_o, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("inv_done", if0.req_accept_o, 1);
    @(posedge clk); #1;

    if0.req_rd_i = 1'b1; if0.req_pc_i = BASE + 40;
    if0.wr_en_i = 1'b1; if0.wr_addr_i = 12'd5;
    if0.wr_data_i = W5; if0.wr_strb_i = 8'hFF;
    @(negedge clk);
    check("wr_blocks", if0.req_accept_o, 0);
    @(posedge clk); #1;
    if0.wr_en_i = 1'b0;
    issue(0, BASE + 40, 2'd3, W5, 0, 0);
    idle(2);

    issue(1, BASE, 2'd3, W0, 0, 0);
    if1.req_rd_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("ws_hold", if1.req_accept_o, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("ws_resp_acc", if1.req_accept_o, 1);
    @(posedge clk); #1;

    issue(1, BASE + 8, 2'd3, W1, 0, 0);
    if1.req_rd_i = 1'b0;
    if1.wr_en_i = 1'b1; if1.wr_addr_i = 12'd1;
    if1.wr_data_i = 64'h0BAD0BAD_0BAD0BAD; if1.wr_strb_i = 8'hFF;
    @(posedge clk); #1;
    if1.wr_en_i = 1'b0;
    idle(5);

    issue(1, BASE + 16, 2'd3, W2, 0, 0);
    if1.req_rd_i = 1'b0;
    rst = 1'b1;
    q1.delete();
    @(negedge clk);
    check("rst_mid_acc1", if1.req_accept_o, 0);
    check("rst_mid_acc0", if0.req_accept_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_valid", if1.resp_valid_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(8);

    issue(1, BASE + 24, 2'd3, W3, 0, 0);
    idle(6);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
